// File: rtl/iob_eth_rx_ctrl_pkg.sv
// Shared definitions for the Ethernet RX control slice: FSM state encoding
// and the default depth of the rx_ready synchroniser.
package iob_eth_rx_ctrl_pkg;

  // RX control FSM states
  typedef enum logic [1:0] {
    RECV    = 2'd0,  // receiver owns its bank, waiting for a frame
    HOLD    = 2'd1,  // frame ready but CPU bank still full: stall receiver
    RELEASE = 2'd2   // rx_receive raised, waiting for ready to drop
  } rx_state_t;

  // Default number of flops synchronising rx_ready into the CPU clock
  localparam int RX_SYNC_STAGES = 2;

endpackage : iob_eth_rx_ctrl_pkg

// File: rtl/iob_eth_sync.sv
// Multi-flop level synchroniser with asynchronous active-low reset.
// Used for the RX frame-ready flag; equally usable for the TX status flag.
module iob_eth_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_reg;

  // Shift the asynchronous level through the flop chain
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_reg[SYNC_STAGES-1];

endmodule : iob_eth_sync

// File: rtl/iob_eth_rx_ctrl.sv
// Ethernet RX controller: sequences the frame receiver through a 4-phase
// ready/receive handshake and ping-pongs the two-bank RX buffer between the
// receiver and the CPU.
// Optional build macro IOB_ETH_RX_DROP_EN: when defined, a frame arriving
// while the CPU bank is still full is discarded (counted in drop_cnt)
// instead of stalling the receiver.
module iob_eth_rx_ctrl
  import iob_eth_rx_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = RX_SYNC_STAGES,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx_ready,
  output logic             rx_receive,
  output logic             rx_bank,
  input  logic             rx_en,
  input  logic             cpu_rx_ack,
  output logic             cpu_bank,
  output logic             frame_avail,
  output logic             irq,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  rx_state_t state_reg;
  logic      rdy_s;
  logic      can_take;
  logic      take;

  iob_eth_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rdy_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (rx_ready),
    .q   (rdy_s)
  );

  // CPU bank is free now, or becomes free this very cycle through an ack
  assign can_take = !frame_avail || cpu_rx_ack;

  // Hand-off: new frame (or a stalled one) meets a free CPU bank while enabled.
  // In HOLD the receiver is still asserting ready, so rdy_s need not be rechecked.
  assign take = rx_en && can_take &&
                (((state_reg == RECV) && rdy_s) || (state_reg == HOLD));

  // Handshake FSM, bank ownership, interrupt and frame counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= RECV;
      rx_receive  <= 1'b0;
      rx_bank     <= 1'b0;
      cpu_bank    <= 1'b1;
      frame_avail <= 1'b0;
      irq         <= 1'b0;
      frame_cnt   <= '0;
`ifdef IOB_ETH_RX_DROP_EN
      drop_cnt    <= '0;
`endif
    end else begin
      irq <= 1'b0;

      // The ack is applied first; a hand-off in the same cycle re-fills below
      if (cpu_rx_ack) begin
        frame_avail <= 1'b0;
      end

      if (take) begin
        cpu_bank    <= rx_bank;
        rx_bank     <= ~rx_bank;
        frame_avail <= 1'b1;
        frame_cnt   <= frame_cnt + CNT_W'(1);
        irq         <= 1'b1;
      end

      case (state_reg)
        RECV: begin
          if (rdy_s && rx_en) begin
            if (can_take) begin
              state_reg  <= RELEASE;
              rx_receive <= 1'b1;
            end else begin
`ifdef IOB_ETH_RX_DROP_EN
              // Release the receiver without swapping: its bank is reused
              state_reg  <= RELEASE;
              rx_receive <= 1'b1;
              if (drop_cnt != {CNT_W{1'b1}}) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
              end
`else
              state_reg <= HOLD;
`endif
            end
          end
        end
        HOLD: begin
          if (take) begin
            state_reg  <= RELEASE;
            rx_receive <= 1'b1;
          end
        end
        RELEASE: begin
          // Only drop receive once the receiver has withdrawn ready
          if (!rdy_s) begin
            state_reg  <= RECV;
            rx_receive <= 1'b0;
          end
        end
        default: begin
          state_reg  <= RECV;
          rx_receive <= 1'b0;
        end
      endcase
    end
  end

`ifndef IOB_ETH_RX_DROP_EN
  assign drop_cnt = '0;
`endif

endmodule : iob_eth_rx_ctrl
